split_beta: RTL
===============

SPLIT_BETA -- requirements
Module: split_beta

Interface
REQ-001 The block SHALL have parameter BIAS, default 32'h9: constant subtracted from each accepted word before serialization.
REQ-002 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: packed word, nibble 0 in bits [3:0].
REQ-007 The block SHALL have port out_valid, output, 1 bit: nibble valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts the nibble.
REQ-009 The block SHALL have port out_data, output, 4 bits: current nibble.
REQ-010 The block SHALL have port out_idx, output, 3 bits: index 0..7 of the current nibble.
REQ-011 The block SHALL have port out_last, output, 1 bit: high when out_idx == 7.

Function
REQ-012 A transfer SHALL occur on a channel only in a cycle where both valid and ready are high at the rising clock edge.
REQ-013 The block SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-015 On an input transfer, the block SHALL load shift register sr = (in_data - BIAS) mod 2^32, load cnt = 0, and enter SHIFT; the borrow SHALL be discarded.
REQ-016 In SHIFT, the block SHALL drive out_valid = 1, out_data = sr[3:0], out_idx = cnt and out_last = (cnt == 7).
REQ-017 The first nibble SHALL be presented in the cycle after the input transfer (latency 1).
REQ-018 On an output transfer with cnt < 7, the block SHALL shift sr right by 4 bits (zero fill), increment cnt, and remain in SHIFT.
REQ-019 On an output transfer with cnt == 7, the block SHALL return to IDLE unless an input transfer occurs in the same cycle.
REQ-020 While out_valid = 1 and out_ready = 0, out_data, out_idx and out_last SHALL hold stable.
REQ-021 In SHIFT, in_ready SHALL be 1 only when cnt == 7 and out_ready == 1 (combinational), allowing zero-bubble back-to-back words.
REQ-022 On a simultaneous last output transfer and input transfer, the block SHALL load the new word per REQ-015 and stay in SHIFT with cnt = 0.
REQ-023 A word SHALL occupy exactly 8 output transfers; sustained throughput SHALL be one nibble per cycle when out_ready is held high.
REQ-024 The block SHALL never drop or duplicate a nibble, and nibbles SHALL be emitted LSB nibble first.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL enter IDLE with sr = 0 and cnt = 0, taking precedence over any handshake in that cycle.
REQ-026 After reset, out_valid SHALL be 0, out_data 0, out_idx 0, out_last 0, in_ready 1.
REQ-027 Reset asserted mid-word SHALL abandon the remaining nibbles, and no nibble of that word SHALL appear after reset deasserts.

Verification
REQ-028 The bench SHALL cover: in_data = 32'h0000_0009, out_ready = 1 -> eight nibbles all 4'h0, with out_last only on the 8th.
REQ-029 The bench SHALL cover: in_data = 32'h8765_4330 -> sr = 32'h8765_4327 -> nibbles 7, 2, 3, 4, 5, 6, 7, 8 at idx 0..7.
REQ-030 The bench SHALL cover wrap-around: in_data = 32'h0000_0005 -> 32'hFFFF_FFFC -> nibbles C, F, F, F, F, F, F, F.
REQ-031 The bench SHALL cover backpressure: out_ready = 0 for 3 cycles while idx = 2 -> out_data, out_idx and out_last held, in_ready = 0, and the sequence resumes intact.
REQ-032 The bench SHALL cover back-to-back words 32'h0000_0009 then 32'h0000_0019 with in_valid and out_ready held high -> 16 consecutive valid cycles with no bubble, the second word yielding 0, 1, 0, 0, 0, 0, 0, 0.
REQ-033 The bench SHALL cover reset at idx = 4 -> out_valid = 0 and in_ready = 1 in the next cycle, and the next word starts at idx 0.

Source files
------------

// File: rtl/split_beta.sv
// split_beta: accepts one 32-bit word, subtracts BIAS, and serializes the
// result as eight 4-bit nibbles, least significant nibble first, over a
// valid/ready output channel. The last nibble can overlap acceptance of the
// next word so back-to-back words stream with no bubble.
module split_beta #(
    parameter logic [31:0] BIAS = 32'h9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic [2:0]  out_idx,
    output logic        out_last
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] sr_r;
    logic [31:0] sr_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        last_s;
    logic [31:0] biased_s;

    assign biased_s = in_data - BIAS;   // borrow out of bit 31 is dropped
    assign last_s   = (cnt_r == 3'd7);

    // Next-state, shift-register and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        cnt_nxt_s   = cnt_r;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    sr_nxt_s    = biased_s;
                    cnt_nxt_s   = 3'd0;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                out_valid_s = 1'b1;
                // A new word may only enter while the final nibble leaves.
                in_ready_s  = last_s && out_ready;
                if (out_ready) begin
                    if (last_s) begin
                        if (in_valid) begin
                            sr_nxt_s    = biased_s;
                            cnt_nxt_s   = 3'd0;
                            state_nxt_s = SHIFT;
                        end else begin
                            // Clear so an idle block presents zeros.
                            sr_nxt_s    = 32'h0;
                            cnt_nxt_s   = 3'd0;
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        sr_nxt_s    = {4'h0, sr_r[31:4]};
                        cnt_nxt_s   = cnt_r + 3'd1;
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    // Stalled: hold everything so the output stays stable.
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                sr_nxt_s    = 32'h0;
                cnt_nxt_s   = 3'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, shift register and nibble counter; reset wins over handshakes
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= 32'h0;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = sr_r[3:0];
    assign out_idx   = cnt_r;
    assign out_last  = last_s;

endmodule
